// File: rtl/cop0_intc_pkg.sv
// CP0 interrupt controller shared constants:
// register map, IP/IM field position and IE stack bits.
package cop0_pkg;

  localparam logic [4:0] ADDR_COUNT  = 5'h09;
  localparam logic [4:0] ADDR_CMP0   = 5'h0B;
  localparam logic [4:0] ADDR_STATUS = 5'h0C;
  localparam logic [4:0] ADDR_CAUSE  = 5'h0D;
  localparam logic [4:0] ADDR_EPC    = 5'h0E;
  localparam logic [4:0] ADDR_CMPN   = 5'h10;

  localparam int IP_LSB  = 10;
  localparam int IP_W    = 6;
  localparam int IEC_BIT = 0;
  localparam int IEP_BIT = 1;

  // Compare0 sits at 0xB, the rest from 0x10 upward
  function automatic logic [4:0] cmp_addr(input int i);
    if (i == 0) return ADDR_CMP0;
    return 5'(int'(ADDR_CMPN) + i - 1);
  endfunction

endpackage

// File: rtl/cop0_intc_if.sv
// mtc0/mfc0 data port and pipeline interrupt
// signals between the core and the CP0 controller.
interface cop0_intc_if;
  logic [4:0]  DataAddress;
  logic [31:0] DataOut;
  logic        DataInEnable;
  logic [31:0] DataIn;
  logic [31:0] InterruptedPC;
  logic        InterruptHandled;
  logic        InterruptReturn;
  logic        InterruptRequest;
  logic [2:0]  InterruptIndex;

  modport master (
    output DataAddress, DataInEnable, DataIn,
    output InterruptedPC, InterruptHandled,
    output InterruptReturn,
    input  DataOut, InterruptRequest, InterruptIndex
  );

  modport slave (
    input  DataAddress, DataInEnable, DataIn,
    input  InterruptedPC, InterruptHandled,
    input  InterruptReturn,
    output DataOut, InterruptRequest, InterruptIndex
  );
endinterface

// File: rtl/cop0_irq_sync.sv
// Two-flop synchroniser for external requests with a
// stall-aware history flop for rising-edge detection.
module cop0_irq_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] prev;

  // prev only advances when enabled so a stalled edge stays visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      if (en) prev <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~prev;

endmodule

// File: rtl/cop0_intc.sv
// Coprocessor-0 interrupt controller: Count/Compare timers,
// RTC wrap, external lines, Status/Cause/EPC and IE stack.
module cop0_intc
  import cop0_pkg::*;
#(
  parameter int          NUM_EXT     = 3,
  parameter int          NUM_TMR     = 2,
  parameter logic [NUM_EXT-1:0] EXT_EDGE = 3'b011,
  parameter int          COUNT_DIV   = 1,
  parameter logic [31:0] COMPARE_RST = 32'h02FA_F080,
  parameter logic [31:0] STATUS_RST  = 32'h0000_8C00
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Enable,
  input  logic [NUM_EXT-1:0] ExtRequest,
  cop0_intc_if.slave         bus
);

  localparam int TMR0 = NUM_EXT;
  localparam int RTC  = NUM_EXT + NUM_TMR;
  localparam logic [7:0] DIV_M1 = 8'(COUNT_DIV - 1);

  logic [31:0]        epc;
  logic [31:0]        count;
  logic [31:0]        status;
  logic [31:0]        cmp [NUM_TMR];
  logic [9:0]         cause_lo;
  logic [15:0]        cause_hi;
  logic [IP_W-1:0]    sticky;
  logic [7:0]         presc;

  logic [NUM_EXT-1:0] lvl;
  logic [NUM_EXT-1:0] rise;
  logic [IP_W-1:0]    set;
  logic [IP_W-1:0]    clr;
  logic [IP_W-1:0]    ip;
  logic [IP_W-1:0]    pend;
  logic [NUM_TMR-1:0] wr_cmp;
  logic [31:0]        count_inc;
  logic               wr_count;
  logic               wr_status;
  logic               wr_cause;
  logic               tick;

  cop0_irq_sync #(.W(NUM_EXT)) u_sync (
    .clk      (Clock),
    .rst_n    (Reset_n),
    .en       (Enable),
    .async_in (ExtRequest),
    .level    (lvl),
    .rise     (rise)
  );

  assign wr_count  = bus.DataInEnable && (bus.DataAddress == ADDR_COUNT);
  assign wr_status = bus.DataInEnable && (bus.DataAddress == ADDR_STATUS);
  assign wr_cause  = bus.DataInEnable && (bus.DataAddress == ADDR_CAUSE);
  assign tick      = (presc == DIV_M1) && !wr_count;
  assign count_inc = count + 32'd1;

  always_comb begin
    wr_cmp = '0;
    for (int i = 0; i < NUM_TMR; i++)
      wr_cmp[i] = bus.DataInEnable && (bus.DataAddress == cmp_addr(i));
  end

  // sets are applied after clears so a coincident set wins
  always_comb begin
    set = '0;
    clr = '0;
    for (int j = 0; j < NUM_EXT; j++)
      if (EXT_EDGE[j]) set[j] = rise[j];
    for (int i = 0; i < NUM_TMR; i++) begin
      set[TMR0+i] = tick && (count_inc == cmp[i]);
      clr[TMR0+i] = wr_cmp[i];
    end
    set[RTC] = tick && (count == 32'hFFFF_FFFF);
    if (wr_cause) clr = clr | ~bus.DataIn[IP_LSB +: IP_W];
  end

  always_comb begin
    ip = sticky;
    for (int j = 0; j < NUM_EXT; j++)
      if (!EXT_EDGE[j]) ip[j] = lvl[j];
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      epc      <= '0;
      count    <= '0;
      presc    <= '0;
      status   <= STATUS_RST & ~32'h3;
      cause_lo <= '0;
      cause_hi <= '0;
      sticky   <= '0;
      for (int i = 0; i < NUM_TMR; i++) cmp[i] <= COMPARE_RST;
    end else if (Enable) begin
      if (wr_count || presc == DIV_M1) presc <= '0;
      else presc <= presc + 8'd1;
      if (wr_count) count <= bus.DataIn;
      else if (tick) count <= count_inc;
      for (int i = 0; i < NUM_TMR; i++)
        if (wr_cmp[i]) cmp[i] <= bus.DataIn;
      sticky <= (sticky & ~clr) | set;
      if (wr_cause) begin
        cause_lo <= bus.DataIn[9:0];
        cause_hi <= bus.DataIn[31:16];
      end
      if (wr_status) status[31:2] <= bus.DataIn[31:2];
      if (bus.InterruptHandled) begin
        epc             <= bus.InterruptedPC;
        status[IEP_BIT] <= status[IEC_BIT];
        status[IEC_BIT] <= 1'b0;
      end else if (bus.InterruptReturn) begin
        status[IEC_BIT] <= status[IEP_BIT];
      end else if (wr_status) begin
        status[1:0] <= bus.DataIn[1:0];
      end
    end
  end

  assign pend = ip & status[IP_LSB +: IP_W];
  assign bus.InterruptRequest = status[IEC_BIT] && (|pend);

  always_comb begin
    bus.InterruptIndex = '0;
    for (int b = 0; b < IP_W; b++)
      if (pend[b]) bus.InterruptIndex = 3'(b);
  end

  always_comb begin
    bus.DataOut = '0;
    unique case (1'b1)
      (bus.DataAddress == ADDR_COUNT):  bus.DataOut = count;
      (bus.DataAddress == ADDR_STATUS): bus.DataOut = status;
      (bus.DataAddress == ADDR_CAUSE):  bus.DataOut = {cause_hi, ip, cause_lo};
      (bus.DataAddress == ADDR_EPC):    bus.DataOut = epc;
      default:                          bus.DataOut = '0;
    endcase
    for (int i = 0; i < NUM_TMR; i++)
      if (bus.DataAddress == cmp_addr(i)) bus.DataOut = cmp[i];
  end

endmodule

// File: tb/tb_cop0_intc.sv
// Directed bench for cop0_intc with a cycle-level reference
// model compared every cycle plus literal spot checks.
module tb_cop0_intc;

  localparam int NE  = 3;
  localparam int NT  = 2;
  localparam int DIV = 4;
  localparam bit [2:0] EDGE = 3'b011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic [NE-1:0] ext = '0;

  cop0_intc_if bus();

  cop0_intc #(
    .NUM_EXT     (NE),
    .NUM_TMR     (NT),
    .EXT_EDGE    (EDGE),
    .COUNT_DIV   (DIV),
    .COMPARE_RST (32'h02FA_F080),
    .STATUS_RST  (32'h0000_8C00)
  ) dut (
    .Clock      (clk),
    .Reset_n    (rst_n),
    .Enable     (en),
    .ExtRequest (ext),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit started = 0;

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // reference model state
  bit [31:0] m_count, m_epc, m_status;
  bit [31:0] m_cmp [NT];
  bit [9:0]  m_clo;
  bit [15:0] m_chi;
  bit [5:0]  m_stk;
  int        m_phase;
  bit [NE-1:0] m_s1, m_s2, m_seen;

  function automatic void m_reset();
    m_count = 0; m_epc = 0; m_status = 32'h0000_8C00;
    for (int i = 0; i < NT; i++) m_cmp[i] = 32'h02FA_F080;
    m_clo = 0; m_chi = 0; m_stk = 0; m_phase = 0;
    m_s1 = 0; m_s2 = 0; m_seen = 0;
  endfunction

  function automatic bit [5:0] m_ip();
    bit [5:0] r = m_stk;
    for (int j = 0; j < NE; j++) if (!EDGE[j]) r[j] = m_s2[j];
    return r;
  endfunction

  function automatic bit m_irq();
    return m_status[0] && ((m_ip() & m_status[15:10]) != 0);
  endfunction

  function automatic bit [2:0] m_idx();
    bit [5:0] p = m_ip() & m_status[15:10];
    for (int b = 5; b >= 0; b--) if (p[b]) return 3'(b);
    return 0;
  endfunction

  function automatic bit [31:0] m_read(logic [4:0] a);
    if (a == 5'h09) return m_count;
    if (a == 5'h0C) return m_status;
    if (a == 5'h0D) return {m_chi, m_ip(), m_clo};
    if (a == 5'h0E) return m_epc;
    for (int i = 0; i < NT; i++)
      if (a == ((i == 0) ? 5'h0B : 5'(16 + i - 1))) return m_cmp[i];
    return 0;
  endfunction

  task automatic m_step();
    bit we = bus.DataInEnable;
    bit [4:0] a = bus.DataAddress;
    bit [31:0] d = bus.DataIn;
    bit [5:0] set = 0, clr = 0;
    bit inc = 0;
    bit [31:0] old = m_count;
    bit iec = m_status[0], iep = m_status[1];
    if (en) begin
      if (we && a == 5'h09) begin
        m_count = d; m_phase = 0;
      end else begin
        m_phase++;
        if (m_phase == DIV) begin m_phase = 0; inc = 1; m_count++; end
      end
      for (int i = 0; i < NT; i++)
        if (inc && m_count == m_cmp[i]) set[NE+i] = 1;
      if (inc && old == 32'hFFFF_FFFF) set[NE+NT] = 1;
      for (int j = 0; j < NE; j++)
        if (EDGE[j] && m_s2[j] && !m_seen[j]) set[j] = 1;
      if (we && a == 5'h0D) begin
        clr = ~d[15:10]; m_clo = d[9:0]; m_chi = d[31:16];
      end
      for (int i = 0; i < NT; i++)
        if (we && a == ((i == 0) ? 5'h0B : 5'(16 + i - 1))) begin
          clr[NE+i] = 1; m_cmp[i] = d;
        end
      m_stk = (m_stk & ~clr) | set;
      if (we && a == 5'h0C) m_status = d;
      if (bus.InterruptHandled) begin
        m_epc = bus.InterruptedPC; m_status[1] = iec; m_status[0] = 0;
      end else if (bus.InterruptReturn) begin
        m_status[0] = iep; m_status[1] = iep;
      end
      m_seen = m_s2;
    end
    m_s2 = m_s1;
    m_s1 = ext;
  endtask

  always @(posedge clk) if (rst_n) m_step();
  always @(negedge rst_n) m_reset();

  always @(negedge clk) if (started) begin
    check("dataout", bus.DataOut, m_read(bus.DataAddress));
    check("irq", {31'b0, bus.InterruptRequest}, {31'b0, m_irq()});
    check("index", {29'b0, bus.InterruptIndex}, {29'b0, m_idx()});
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    bus.DataAddress = a; bus.DataIn = d; bus.DataInEnable = 1'b1;
    cyc(1);
    bus.DataInEnable = 1'b0;
  endtask

  task automatic rd(string nm, logic [4:0] a, logic [31:0] exp);
    bus.DataAddress = a;
    #1;
    check(nm, bus.DataOut, exp);
  endtask

  task automatic irq_is(string nm, bit r, int idx);
    #1;
    check({nm, "_req"}, {31'b0, bus.InterruptRequest}, {31'b0, r});
    if (r) check({nm, "_idx"}, {29'b0, bus.InterruptIndex}, 32'(idx));
  endtask

  initial begin
    bus.DataAddress = 0; bus.DataIn = 0; bus.DataInEnable = 0;
    bus.InterruptedPC = 0; bus.InterruptHandled = 0; bus.InterruptReturn = 0;
    m_reset();
    cyc(2);
    started = 1;
    rst_n = 1'b1;
    wr(5'h0C, 32'h0000_FC01);
    wr(5'h09, 32'h0000_1234);
    cyc(2);
    // asynchronous reset between clock edges
    bus.DataAddress = 5'h0C;
    #1 rst_n = 1'b0;
    #1 check("rst_status", bus.DataOut, 32'h0000_8C00);
    check("rst_irq", {31'b0, bus.InterruptRequest}, 0);
    rd("rst_count", 5'h09, 32'h0);
    cyc(1);
    rd("rst_cmp0", 5'h0B, 32'h02FA_F080);
    rd("rst_cause", 5'h0D, 32'h0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    // timer1
    wr(5'h0C, 32'h0000_4001);
    wr(5'h09, 32'h0000_0010);
    wr(5'h10, 32'h0000_0014);
    cyc(14);
    irq_is("tmr_before", 0, 0);
    cyc(1);
    irq_is("tmr_hit", 1, 4);
    rd("tmr_cause", 5'h0D, 32'h0000_4000);
    rd("tmr_count", 5'h09, 32'h0000_0014);
    wr(5'h10, 32'h0000_0100);
    irq_is("tmr_clr", 0, 0);

    // edge line 0
    wr(5'h0C, 32'h0000_0401);
    ext[0] = 1; cyc(1);
    ext[0] = 0; cyc(1);
    irq_is("edge_early", 0, 0);
    cyc(1);
    irq_is("edge_set", 1, 0);
    rd("edge_cause", 5'h0D, 32'h0000_0400);
    cyc(3);
    irq_is("edge_sticky", 1, 0);
    wr(5'h0D, 32'h0);
    irq_is("edge_w0c", 0, 0);
    ext[0] = 1; cyc(1);
    ext[0] = 0; cyc(1);
    wr(5'h0D, 32'h0);
    rd("edge_setwins", 5'h0D, 32'h0000_0400);
    wr(5'h0D, 32'h0);

    // level line 2
    wr(5'h0C, 32'h0000_1001);
    ext[2] = 1; cyc(1);
    irq_is("lvl_lat1", 0, 0);
    cyc(1);
    irq_is("lvl_on", 1, 2);
    wr(5'h0D, 32'h0);
    irq_is("lvl_nowrite", 1, 2);
    ext[2] = 0; cyc(1);
    irq_is("lvl_hold", 1, 2);
    cyc(1);
    irq_is("lvl_off", 0, 0);

    // handler entry / return
    ext[2] = 1; cyc(2);
    bus.InterruptedPC = 32'h400; bus.InterruptHandled = 1; cyc(1);
    bus.InterruptHandled = 0;
    rd("hnd_epc", 5'h0E, 32'h400);
    rd("hnd_status", 5'h0C, 32'h0000_1002);
    irq_is("hnd_irq", 0, 0);
    bus.InterruptReturn = 1; cyc(1);
    bus.InterruptReturn = 0;
    rd("ret_status", 5'h0C, 32'h0000_1003);
    irq_is("ret_irq", 1, 2);
    ext[2] = 0;
    bus.InterruptedPC = 32'h800; bus.InterruptHandled = 1;
    wr(5'h0C, 32'h0000_2000);
    bus.InterruptHandled = 0;
    rd("hnd_wr_status", 5'h0C, 32'h0000_2002);
    bus.InterruptedPC = 32'hC00;
    bus.InterruptHandled = 1; bus.InterruptReturn = 1; cyc(1);
    bus.InterruptHandled = 0; bus.InterruptReturn = 0;
    rd("hnd_ret_status", 5'h0C, 32'h0000_2000);
    wr(5'h0E, 32'hDEAD_BEEF);
    rd("epc_ro", 5'h0E, 32'hC00);
    wr(5'h05, 32'hFFFF_FFFF);
    rd("unmapped", 5'h05, 32'h0);

    // RTC wrap with prescaler
    wr(5'h0C, 32'h0000_8001);
    wr(5'h09, 32'hFFFF_FFFF);
    cyc(3);
    rd("rtc_pre", 5'h09, 32'hFFFF_FFFF);
    irq_is("rtc_pre", 0, 0);
    cyc(1);
    rd("rtc_wrap", 5'h09, 32'h0);
    irq_is("rtc_wrap", 1, 5);
    rd("rtc_cause", 5'h0D, 32'h0000_8000);
    wr(5'h0D, 32'h0);
    irq_is("rtc_w0c", 0, 0);

    // same wrap stretched by a 3-cycle stall
    wr(5'h09, 32'hFFFF_FFFF);
    en = 0; cyc(3);
    en = 1; cyc(3);
    rd("stall_pre", 5'h09, 32'hFFFF_FFFF);
    irq_is("stall_pre", 0, 0);
    cyc(1);
    rd("stall_wrap", 5'h09, 32'h0);
    irq_is("stall_wrap", 1, 5);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
